// File: rtl/map_cursor_editor.sv
// Cursor/map editor for a 16x16 life grid: five debounced buttons move a cursor
// and toggle cells, and the life engine can overwrite the whole map at any time.
module map_cursor_editor #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   btn_in,
  input  logic         edit_en,
  input  logic         load_valid,
  input  logic [255:0] map_in,
  output logic [3:0]   position_x,
  output logic [3:0]   position_y,
  output logic [7:0]   cell_index,
  output logic [255:0] map,
  output logic         led,
  output logic [4:0]   press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0][CW-1:0] cnt_q, cnt_d;
  logic [4:0]         lvl_q, lvl_d;
  logic [4:0]         lvl_dly_q;
  logic [4:0]         press_q, press_d;
  logic [3:0]         x_q, x_d, y_q, y_d;
  logic [255:0]       map_q, map_d;

  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (btn_in[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Edge detect on the registered level so the pulse lands one cycle after acceptance.
  assign press_d = lvl_q & ~lvl_dly_q;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    map_d = map_q;
    if (edit_en) begin
      x_d = x_q + 4'(press_q[0]) - 4'(press_q[2]);
      y_d = y_q + 4'(press_q[1]) - 4'(press_q[3]);
      if (press_q[4]) begin
        map_d[{y_q, x_q}] = ~map_q[{y_q, x_q}];
      end
    end
    if (load_valid) begin
      map_d = map_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      press_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      map_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      press_q   <= press_d;
      x_q       <= x_d;
      y_q       <= y_d;
      map_q     <= map_d;
    end
  end

  assign position_x = x_q;
  assign position_y = y_q;
  assign cell_index = {y_q, x_q};
  assign map        = map_q;
  assign led        = map_q[{y_q, x_q}];
  assign press      = press_q;

endmodule

// File: tb/tb_map_cursor_editor.sv
// Randomized plus directed bench for map_cursor_editor; a queue-based scoreboard
// holds the reference model's expected outputs for each clock edge.
module tb_map_cursor_editor;

  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   btn_in;
  logic         edit_en;
  logic         load_valid;
  logic [255:0] map_in;
  logic [3:0]   position_x, position_y;
  logic [7:0]   cell_index;
  logic [255:0] map;
  logic         led;
  logic [4:0]   press;

  map_cursor_editor #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .edit_en    (edit_en),
    .load_valid (load_valid),
    .map_in     (map_in),
    .position_x (position_x),
    .position_y (position_y),
    .cell_index (cell_index),
    .map        (map),
    .led        (led),
    .press      (press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   x;
    logic [3:0]   y;
    logic [255:0] map;
    logic [4:0]   press;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: raw sample history since the last accepted change.
  logic [3:0]   m_x, m_y;
  logic [255:0] m_map;
  logic [4:0]   m_press, m_acc, m_acc_prev;
  int           hist[5][$];

  task automatic model_step(input logic r, input logic [4:0] b, input logic en,
                            input logic ld, input logic [255:0] mi);
    logic [4:0] np;
    if (r) begin
      m_x = 0; m_y = 0; m_map = '0; m_press = '0; m_acc = '0; m_acc_prev = '0;
      for (int i = 0; i < 5; i++) hist[i].delete();
    end else begin
      if (en) begin
        if (m_press[4]) m_map[m_y * 16 + m_x] = ~m_map[m_y * 16 + m_x];
        if (m_press[0]) m_x = m_x + 1;
        if (m_press[2]) m_x = m_x - 1;
        if (m_press[1]) m_y = m_y + 1;
        if (m_press[3]) m_y = m_y - 1;
      end
      if (ld) m_map = mi;
      np = m_acc & ~m_acc_prev;
      m_acc_prev = m_acc;
      for (int i = 0; i < 5; i++) begin
        int differ;
        hist[i].push_back(int'(b[i]));
        if (hist[i].size() > DEB) void'(hist[i].pop_front());
        differ = 0;
        foreach (hist[i][k]) if (hist[i][k] != int'(m_acc[i])) differ++;
        if (differ == DEB) begin
          m_acc[i] = ~m_acc[i];
          hist[i].delete();
        end
      end
      m_press = np;
    end
  endtask

  task automatic cycle(input logic r, input logic [4:0] b, input logic en,
                       input logic ld, input logic [255:0] mi);
    exp_t e;
    rst = r; btn_in = b; edit_en = en; load_valid = ld; map_in = mi;
    @(posedge clk);
    model_step(r, b, en, ld, mi);
    e.x = m_x; e.y = m_y; e.map = m_map; e.press = m_press;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic [4:0] b, input logic en, input int n, input int load_at);
    for (int i = 0; i < n; i++) cycle(1'b0, b, en, (i == load_at), '1);
  endtask

  task automatic tap(input int bit_i, input int times);
    logic [4:0] b;
    b = '0;
    b[bit_i] = 1'b1;
    for (int t = 0; t < times; t++) begin
      hold(b, 1'b1, 7, -1);
      hold(5'd0, 1'b1, 6, -1);
    end
  endtask

  // Monitor: every output sample is compared against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({position_y, position_x} !== {e.y, e.x}) begin
          errors++;
          $display("FAIL cursor: got y=%0d x=%0d expected y=%0d x=%0d at %0t",
                   position_y, position_x, e.y, e.x, $time);
        end
        checks++;
        if (cell_index !== {e.y, e.x}) begin
          errors++;
          $display("FAIL cell_index: got %h expected %h at %0t", cell_index, {e.y, e.x}, $time);
        end
        checks++;
        if (press !== e.press) begin
          errors++;
          $display("FAIL press: got %b expected %b at %0t", press, e.press, $time);
        end
        checks++;
        if (map !== e.map) begin
          errors++;
          $display("FAIL map: got %h expected %h at %0t", map, e.map, $time);
        end
        checks++;
        if (led !== e.map[{e.y, e.x}]) begin
          errors++;
          $display("FAIL led: got %b expected %b at %0t", led, e.map[{e.y, e.x}], $time);
        end
      end
    end
  end

  initial begin
    logic [4:0]   b;
    logic [255:0] mi;
    int           dur[5];

    cycle(1'b1, '0, 1'b1, 1'b0, '0);
    cycle(1'b1, '0, 1'b1, 1'b0, '0);

    hold(5'b00001, 1'b1, 10, -1);          // single press, x -> 1
    hold(5'b00000, 1'b1, 6, -1);
    tap(2, 2);                             // x: 1 -> 0 -> 15
    tap(3, 1);                             // y: 0 -> 15
    tap(0, 2);                             // x: 15 -> 0 -> 1
    tap(1, 3);                             // y: 15 -> 2, cursor (1,2)
    tap(4, 1);                             // map[33] set
    tap(4, 1);                             // map[33] cleared
    hold(5'b00001, 1'b1, 3, -1);           // glitch shorter than debounce
    hold(5'b00000, 1'b1, 6, -1);
    hold(5'b10000, 1'b1, 8, 5);            // toggle coincides with load of all ones
    hold(5'b00000, 1'b1, 6, -1);
    hold(5'b00010, 1'b0, 8, -1);           // press discarded with edits disabled
    hold(5'b00000, 1'b0, 6, -1);
    tap(4, 1);
    tap(0, 6);
    tap(1, 7);                             // cursor (7,9)
    hold(5'b00001, 1'b1, 3, -1);           // reset mid-press
    cycle(1'b1, 5'b00001, 1'b1, 1'b0, '0);
    hold(5'b00001, 1'b1, 8, -1);
    hold(5'b00000, 1'b1, 4, -1);

    for (int i = 0; i < 5; i++) dur[i] = 0;
    b = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (dur[i] == 0) begin
          b[i] = 1'($urandom_range(0, 1));
          dur[i] = int'($urandom_range(1, 10));
        end
        dur[i]--;
      end
      for (int k = 0; k < 8; k++) mi[k*32 +: 32] = $urandom;
      cycle(($urandom_range(0, 199) == 0), b, ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 29) == 0), mi);
    end

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_cursor_editor.md
MAP_CURSOR_EDITOR -- requirements
Module: map_cursor_editor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port btn_in  input  5  raw buttons: [0] right, [1] down, [2] left, [3] up, [4] toggle cell.
REQ-005 SHALL have port edit_en  input  1  1 = button actions applied, 0 = debounced presses discarded.
REQ-006 SHALL have port load_valid  input  1  1 = replace whole map with map_in this cycle.
REQ-007 SHALL have port map_in  input  256  next-generation map from the life engine.
REQ-008 SHALL have port position_x  output  4  cursor column.
REQ-009 SHALL have port position_y  output  4  cursor row.
REQ-010 SHALL have port cell_index  output  8  {position_y, position_x}.
REQ-011 SHALL have port map  output  256  registered map; cell (x,y) at bit y*16+x.
REQ-012 SHALL have port led  output  1  map bit at cell_index (combinational from registers).
REQ-013 SHALL have port press  output  5  one-cycle debounced press pulses, per button.

Function
REQ-014 SHALL debounce each btn_in bit independently: per-bit counter and accepted level; counter increments while raw != accepted, clears when raw == accepted.
REQ-015 SHALL flip the accepted level when the counter reaches DEBOUNCE_CYCLES-1 while raw still differs, clearing the counter in the same cycle.
REQ-016 SHALL assert press[i] for exactly one cycle, the cycle after accepted level of bit i goes 0->1; no pulse on 1->0.
REQ-017 SHALL produce no further press[i] while the button is held; re-arm only after accepted level returns to 0.
REQ-018 SHALL treat glitches shorter than DEBOUNCE_CYCLES as ignored (counter clears on return to accepted level).
REQ-019 SHALL, in the cycle after press is high with edit_en=1, update the cursor: right x+1, left x-1, down y+1, up y-1, all mod 16 (15+1 wraps to 0, 0-1 wraps to 15).
REQ-020 SHALL apply simultaneous pulses together: right+left cancel (x unchanged), down+up cancel (y unchanged), x and y moves combine.
REQ-021 SHALL, for press[4] with edit_en=1, invert map bit at the cursor value held before any same-cycle move.
REQ-022 SHALL, when load_valid=1, load map <= map_in; load has priority over toggle in the same cycle (toggle dropped); cursor moves still apply.
REQ-023 SHALL discard press pulses occurring while edit_en=0 (not queued); debounce continues running.
REQ-024 SHALL keep latency fixed: raw stable edge -> press pulse = DEBOUNCE_CYCLES+1 cycles; press -> position/map update = 1 cycle.
REQ-025 SHALL require DEBOUNCE_CYCLES >= 2; counter width = clog2(DEBOUNCE_CYCLES)+1, no overflow possible.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set position_x=0, position_y=0, map=0, press=0, all debounce counters and accepted levels to 0; led therefore 0.
REQ-027 SHALL give rst priority over load_valid, press and edit actions in the same cycle.
REQ-028 SHALL, on reset mid-press, require the button to be seen stable high for a full DEBOUNCE_CYCLES after reset deassertion before a press pulse.

Verification (DEBOUNCE_CYCLES=4, edit_en=1 unless stated)
REQ-029 SHALL cover: btn_in[0] high 10 cycles from reset -> single press[0] pulse 5 cycles after rise, position_x=1, no second pulse.
REQ-030 SHALL cover: btn_in[2] pressed once from x=0 -> position_x=15; btn_in[3] once from y=0 -> position_y=15, cell_index=8'hFF.
REQ-031 SHALL cover: cursor (1,2), btn_in[4] pressed -> map[33]=1, led=1; pressed again -> map[33]=0, led=0.
REQ-032 SHALL cover: btn_in[0] high 3 cycles then low -> no press[0], position unchanged.
REQ-033 SHALL cover: press[4] pulse coincident with load_valid=1, map_in=all-ones -> map all ones (toggle dropped); edit_en=0 with press[1] -> position_y unchanged.
REQ-034 SHALL cover: rst asserted while map nonzero and cursor (7,9) -> next cycle position 0,0, map=0, press=0, led=0.
